// File: rtl/fib_breathing_pwm_mc_if.sv
`default_nettype none
// ============================================================================
// Module   : fib_breathing_pwm_mc_if
// Purpose  : Bundles the control and status signals of the multi-channel
//            Fibonacci breathing PWM so one handle carries the whole bus.
// Ports    : clr       - synchronous clear of every channel
//            ch_en     - per-channel run enable
//            mode      - per-channel mode, 0 = wrap, 1 = breathe
//            pwm_out   - registered PWM outputs
//            term      - current term per channel, ch i at [i*WIDTH +: WIDTH]
//            term_done - one-cycle pulse when a channel's LOW phase ends
// Revision : 1.0 - initial release
// ============================================================================
interface fib_breathing_pwm_mc_if #(
  parameter int WIDTH  = 8,
  parameter int NUM_CH = 4
);
  logic                      clr;
  logic [NUM_CH-1:0]         ch_en;
  logic [NUM_CH-1:0]         mode;
  logic [NUM_CH-1:0]         pwm_out;
  logic [NUM_CH*WIDTH-1:0]   term;
  logic [NUM_CH-1:0]         term_done;

  modport master (
    output clr, ch_en, mode,
    input  pwm_out, term, term_done
  );

  modport slave (
    input  clr, ch_en, mode,
    output pwm_out, term, term_done
  );
endinterface
`default_nettype wire

// File: rtl/fib_breathing_pwm_mc.sv
`default_nettype none
// ============================================================================
// Module   : fib_breathing_pwm_mc
// Purpose  : NUM_CH independent PWM channels whose HIGH/LOW phase lengths
//            step through the Fibonacci sequence, either wrapping back to 1
//            or breathing up to the largest in-range term and back down.
// Ports    : clk   - clock
//            rst_n - asynchronous active-low reset
//            bus   - slave modport: clr, ch_en, mode in; pwm_out, term,
//                    term_done out
// Revision : 1.0 - initial release
// ============================================================================
module fib_breathing_pwm_mc #(
  parameter int WIDTH    = 8,
  parameter int NUM_CH   = 4,
  parameter int PRESCALE = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  fib_breathing_pwm_mc_if.slave   bus
);

  typedef enum logic {PH_LOW = 1'b0, PH_HIGH = 1'b1} phase_e;
  typedef enum logic {DIR_UP = 1'b0, DIR_DN  = 1'b1} dir_e;

  localparam int               C_PW        = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [C_PW-1:0]  C_PRESC_MAX = C_PW'(PRESCALE - 1);
  localparam logic [WIDTH-1:0] C_ONE       = WIDTH'(1);

  // Shared free-running prescaler; only rst_n and clr restart it.
  logic [C_PW-1:0] presc_q;
  logic [C_PW-1:0] presc_d;
  logic            tick;

  always_comb begin
    tick    = (presc_q == C_PRESC_MAX);
    presc_d = tick ? '0 : presc_q + 1'b1;
    if (bus.clr) begin
      presc_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end

  logic [NUM_CH-1:0]       pwm_vec;
  logic [NUM_CH-1:0]       done_vec;
  logic [NUM_CH*WIDTH-1:0] term_vec;

  generate
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      logic [WIDTH-1:0] a_q,   a_d;
      logic [WIDTH-1:0] b_q,   b_d;
      logic [WIDTH-1:0] cnt_q, cnt_d;
      phase_e           phase_q, phase_d;
      dir_e             dir_q,   dir_d;
      logic             first_q, first_d;
      logic             pwm_q,   pwm_d;
      logic             done_q,  done_d;
      logic [WIDTH:0]   sum;
      logic             ovf;

      always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        phase_d = phase_q;
        dir_d   = dir_q;
        first_d = first_q;
        done_d  = 1'b0;
        pwm_d   = 1'b0;
        // One extra bit catches the step past the largest representable term.
        sum     = {1'b0, a_q} + {1'b0, b_q};
        ovf     = sum[WIDTH];

        if (bus.clr) begin
          a_d     = '0;
          b_d     = C_ONE;
          cnt_d   = C_ONE;
          phase_d = PH_LOW;
          dir_d   = DIR_UP;
          first_d = 1'b1;
        end else if (bus.ch_en[i]) begin
          if (tick) begin
            if (cnt_q != C_ONE) begin
              cnt_d = cnt_q - 1'b1;
            end else if (phase_q == PH_HIGH) begin
              phase_d = PH_LOW;
              cnt_d   = b_q;
            end else if (first_q) begin
              // The single LOW tick out of reset does not advance the pair.
              first_d = 1'b0;
              phase_d = PH_HIGH;
              cnt_d   = b_q;
            end else begin
              done_d  = 1'b1;
              phase_d = PH_HIGH;
              if (dir_q == DIR_UP && !ovf) begin
                a_d = b_q;
                b_d = sum[WIDTH-1:0];
              end else if (dir_q == DIR_UP && !bus.mode[i]) begin
                a_d = '0;
                b_d = C_ONE;
              end else if (dir_q == DIR_DN && a_q == '0) begin
                // Bottom of the trough: (0,1) -> (1,1), climbing again.
                dir_d = DIR_UP;
                a_d   = C_ONE;
                b_d   = C_ONE;
              end else begin
                // Reverse step (a,b) -> (b-a,a); entered from the top in
                // breathe mode, and kept while descending regardless of mode.
                dir_d = DIR_DN;
                a_d   = b_q - a_q;
                b_d   = a_q;
              end
              cnt_d = b_d;
            end
          end
          pwm_d = (phase_d == PH_HIGH);
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q     <= '0;
          b_q     <= C_ONE;
          cnt_q   <= C_ONE;
          phase_q <= PH_LOW;
          dir_q   <= DIR_UP;
          first_q <= 1'b1;
          pwm_q   <= 1'b0;
          done_q  <= 1'b0;
        end else begin
          a_q     <= a_d;
          b_q     <= b_d;
          cnt_q   <= cnt_d;
          phase_q <= phase_d;
          dir_q   <= dir_d;
          first_q <= first_d;
          pwm_q   <= pwm_d;
          done_q  <= done_d;
        end
      end

      assign pwm_vec[i]                = pwm_q;
      assign done_vec[i]               = done_q;
      assign term_vec[i*WIDTH +: WIDTH] = b_q;
    end
  endgenerate

  assign bus.pwm_out   = pwm_vec;
  assign bus.term_done = done_vec;
  assign bus.term      = term_vec;

endmodule
`default_nettype wire

// File: tb/tb_fib_breathing_pwm_mc.sv
`default_nettype none
// ============================================================================
// Module   : tb_fib_breathing_pwm_mc
// Purpose  : Self-checking bench for fib_breathing_pwm_mc. Two instances
//            (prescale 1 and 4) are compared every cycle against a model
//            that tracks each channel's position in a Fibonacci term table.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fib_breathing_pwm_mc;
  localparam int W  = 8;
  localparam int N1 = 4;
  localparam int N4 = 2;
  localparam int NM = N1 + N4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fib_breathing_pwm_mc_if #(.WIDTH(W), .NUM_CH(N1)) if1 ();
  fib_breathing_pwm_mc_if #(.WIDTH(W), .NUM_CH(N4)) if4 ();

  fib_breathing_pwm_mc #(.WIDTH(W), .NUM_CH(N1), .PRESCALE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(if1));
  fib_breathing_pwm_mc #(.WIDTH(W), .NUM_CH(N4), .PRESCALE(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .bus(if4));

  int vectors     = 0;
  int miscompares = 0;

  // Term table: fib[0]=1 is the reset pair (0,1); fib[top_idx] is the
  // largest term that fits in W bits.
  int fib[0:31];
  int top_idx;

  // Model channels 0..3 belong to dut1, 4..5 to dut4.
  int m_idx[NM], m_up[NM], m_first[NM], m_hi[NM], m_rem[NM], m_pwm[NM], m_done[NM];
  int pc1, pc4;

  int rl_len[N4], rl_val[N4], rl_term[N4], rl_valid[N4];
  int run3_checks = 0;

  int pat[19] = '{1,0,1,0,1,1,0,0,1,1,1,0,0,0,1,1,1,1,1};

  task automatic chk(input string tag, input int ch, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s ch%0d observed=%0d expected=%0d", tag, ch, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NM; c++) begin
      m_idx[c] = 0; m_up[c] = 1; m_first[c] = 1; m_hi[c] = 0;
      m_rem[c] = 1; m_pwm[c] = 0; m_done[c] = 0;
    end
    pc1 = 0;
    pc4 = 0;
  endtask

  task automatic advance(input int c, input bit md);
    if (m_up[c] == 1) begin
      if (m_idx[c] < top_idx) m_idx[c]++;
      else if (!md)           m_idx[c] = 0;
      else begin m_up[c] = 0; m_idx[c]--; end
    end else begin
      if (m_idx[c] > 0) m_idx[c]--;
      else begin m_up[c] = 1; m_idx[c] = 1; end
    end
  endtask

  task automatic model_edge();
    bit t1, t4, en, md, t;
    if (if1.clr) begin
      model_reset();
      return;
    end
    t1  = 1'b1;
    t4  = (pc4 == 3);
    pc4 = t4 ? 0 : pc4 + 1;
    for (int c = 0; c < NM; c++) begin
      en = (c < N1) ? if1.ch_en[c] : if4.ch_en[c-N1];
      md = (c < N1) ? if1.mode[c]  : if4.mode[c-N1];
      t  = (c < N1) ? t1 : t4;
      m_done[c] = 0;
      if (!en) begin
        m_pwm[c] = 0;
      end else begin
        if (t) begin
          if (m_rem[c] > 1) begin
            m_rem[c]--;
          end else if (m_hi[c] == 1) begin
            m_hi[c]  = 0;
            m_rem[c] = fib[m_idx[c]];
          end else begin
            if (m_first[c] == 1) m_first[c] = 0;
            else begin advance(c, md); m_done[c] = 1; end
            m_hi[c]  = 1;
            m_rem[c] = fib[m_idx[c]];
          end
        end
        m_pwm[c] = m_hi[c];
      end
    end
  endtask

  task automatic check_all();
    for (int c = 0; c < N1; c++) begin
      chk("pwm1",  c, 32'(if1.pwm_out[c]),       m_pwm[c]);
      chk("term1", c, 32'(if1.term[c*W +: W]),   fib[m_idx[c]]);
      chk("done1", c, 32'(if1.term_done[c]),     m_done[c]);
    end
    for (int c = 0; c < N4; c++) begin
      chk("pwm4",  c, 32'(if4.pwm_out[c]),       m_pwm[N1+c]);
      chk("term4", c, 32'(if4.term[c*W +: W]),   fib[m_idx[N1+c]]);
      chk("done4", c, 32'(if4.term_done[c]),     m_done[N1+c]);
    end
  endtask

  task automatic run_reset();
    for (int k = 0; k < N4; k++) begin
      rl_valid[k] = 0; rl_val[k] = 0; rl_len[k] = 0; rl_term[k] = 0;
    end
  endtask

  // Measures complete HIGH/LOW runs on the prescale-4 instance; a term of
  // 3 must give runs of exactly 12 clocks.
  task automatic run_track(input bit restart);
    int p, tv;
    for (int k = 0; k < N4; k++) begin
      p  = int'(if4.pwm_out[k]);
      tv = int'(if4.term[k*W +: W]);
      if (restart) begin
        rl_valid[k] = 0; rl_val[k] = p; rl_len[k] = 1;
      end else if (p == rl_val[k]) begin
        rl_len[k]++;
      end else begin
        if (rl_valid[k] == 1 && rl_term[k] == 3) begin
          chk("run3", k, rl_len[k], 12);
          run3_checks++;
        end
        rl_valid[k] = 1; rl_val[k] = p; rl_len[k] = 1; rl_term[k] = tv;
      end
    end
  endtask

  task automatic do_cycle();
    bit was_clr;
    was_clr = if1.clr;
    model_edge();
    @(posedge clk);
    #1;
    check_all();
    run_track(was_clr);
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    run_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_pattern();
    for (int k = 0; k < 19; k++) begin
      do_cycle();
      chk("pattern", 0, 32'(if1.pwm_out[0]), pat[k]);
    end
  endtask

  initial begin
    int guard;
    int j;
    fib[0] = 1;
    fib[1] = 1;
    top_idx = 1;
    for (int k = 2; k < 32; k++) begin
      fib[k] = fib[k-1] + fib[k-2];
      if (fib[k] <= (1 << W) - 1) top_idx = k;
    end

    if1.clr = 1'b0; if4.clr = 1'b0;
    if1.ch_en = '1; if1.mode = 4'($urandom_range(0, 15));
    if4.ch_en = '1; if4.mode = 2'b10;
    model_reset();
    run_reset();

    // Reset state, then the opening pattern.
    apply_reset();
    run_pattern();

    // Long run: wrap on ch0/ch2, breathe on ch1/ch3 through top and trough.
    if1.mode = 4'b1010;
    repeat (3000) do_cycle();

    // Drop ch0 mid-HIGH for 7 cycles, then resume.
    guard = 0;
    while (!(m_hi[0] == 1 && m_rem[0] >= 3) && guard < 2000) begin
      do_cycle();
      guard++;
    end
    chk("find_high", 0, 32'(guard < 2000), 1);
    if1.ch_en[0] = 1'b0;
    repeat (7) do_cycle();
    if1.ch_en[0] = 1'b1;
    repeat (40) do_cycle();

    // Random enables and mode changes.
    repeat (3000) begin
      if ($urandom_range(0, 15) == 0) begin
        j = int'($urandom_range(0, N1-1));
        if1.ch_en[j] = ~if1.ch_en[j];
      end
      if ($urandom_range(0, 63) == 0) begin
        j = int'($urandom_range(0, N1-1));
        if1.mode[j] = ~if1.mode[j];
      end
      do_cycle();
    end

    // Synchronous clear mid-phase; the opening pattern must recur.
    if1.ch_en = '1;
    repeat (5) do_cycle();
    if1.clr = 1'b1; if4.clr = 1'b1;
    do_cycle();
    if1.clr = 1'b0; if4.clr = 1'b0;
    run_pattern();

    // Asynchronous reset mid-phase.
    repeat (37) do_cycle();
    apply_reset();
    run_pattern();

    repeat (1500) begin
      if ($urandom_range(0, 31) == 0) if1.mode = 4'($urandom_range(0, 15));
      do_cycle();
    end

    chk("run3_seen", 0, 32'(run3_checks > 0), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
`default_nettype wire
